// File: rtl/muladd_divider_if.sv
// Operand/result bundle between the multiply-add controller and the divider.
// The controller is the master; the divider is the slave.
interface muladd_divider_if #(
  parameter int unsigned size = 8
);
  logic              start;
  logic [2*size-1:0] dividend;
  logic [size-1:0]   divisor;
  logic [2*size-1:0] quotient;
  logic [size-1:0]   remainder;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic              ovf;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero, ovf
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero, ovf
  );
endinterface

// File: rtl/muladd_divider.sv
// Restoring divider that splits dividend = A*B + C back into A (quotient) and C (remainder),
// producing one quotient bit per clock.
module muladd_divider #(
  parameter int unsigned size = 8
) (
  input logic             clk,
  input logic             rst_n,
  muladd_divider_if.slave bus
);

  localparam int unsigned DW   = 2 * size;
  localparam int unsigned CntW = $clog2(DW);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     dvd_q, dvd_d;
  logic [size-1:0]   dvs_q, dvs_d;
  logic [size-1:0]   part_q, part_d;
  logic [DW-1:0]     quo_q, quo_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]     quotient_q, quotient_d;
  logic [size-1:0]   remainder_q, remainder_d;
  logic              div_zero_q, div_zero_d;
  logic              ovf_q, ovf_d;

  logic [size:0]     shifted;
  logic [size:0]     diff;
  logic              qbit;
  logic [DW-1:0]     quo_next;
  logic [size-1:0]   part_next;

  always_comb begin
    // The held partial remainder is always below the divisor, so size bits suffice; the
    // shifted value needs one more. A clear borrow in diff means shifted >= divisor.
    shifted   = {part_q, dvd_q[DW-1]};
    diff      = shifted - {1'b0, dvs_q};
    qbit      = ~diff[size];
    quo_next  = {quo_q[DW-2:0], qbit};
    part_next = qbit ? diff[size-1:0] : shifted[size-1:0];

    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    ovf_d       = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          dvd_d  = bus.dividend;
          dvs_d  = bus.divisor;
          part_d = '0;
          quo_d  = '0;
          if (bus.divisor != '0) begin
            state_d = StCalc;
            cnt_d   = CntW'(DW - 1);
          end else begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = bus.dividend[size-1:0];
            div_zero_d  = 1'b1;
            ovf_d       = 1'b0;
          end
        end
      end
      StCalc: begin
        dvd_d  = dvd_q << 1;
        part_d = part_next;
        quo_d  = quo_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = StDone;
          quotient_d  = quo_next;
          remainder_d = part_next;
          div_zero_d  = 1'b0;
          ovf_d       = |quo_next[DW-1:size];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dvd_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state_q == StCalc);
  assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_muladd_divider.sv
// Scoreboard bench for muladd_divider: expected results are queued at the accepting edge and
// compared whenever done pulses.
module tb_muladd_divider;

  localparam int unsigned Size = 8;

  typedef struct packed {
    logic [2*Size-1:0] q;
    logic [Size-1:0]   r;
    logic              dz;
    logic              ov;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   op_idx;
  exp_t sb[$];

  muladd_divider_if #(.size(Size)) bus ();

  muladd_divider #(.size(Size)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [2*Size-1:0] dvd, input logic [Size-1:0] dvs);
    exp_t e;
    if (dvs == '0) begin
      e.q  = '1;
      e.r  = dvd[Size-1:0];
      e.dz = 1'b1;
      e.ov = 1'b0;
    end else begin
      e.q  = dvd / {{Size{1'b0}}, dvs};
      e.r  = Size'(dvd % {{Size{1'b0}}, dvs});
      e.dz = 1'b0;
      e.ov = (e.q[2*Size-1:Size] != '0);
    end
    return e;
  endfunction

  // Result monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          e = sb.pop_front();
          check($sformatf("op%0d.quotient", op_idx), 32'(bus.quotient), 32'(e.q));
          check($sformatf("op%0d.remainder", op_idx), 32'(bus.remainder), 32'(e.r));
          check($sformatf("op%0d.div_zero", op_idx), 32'(bus.div_zero), 32'(e.dz));
          check($sformatf("op%0d.ovf", op_idx), 32'(bus.ovf), 32'(e.ov));
          op_idx++;
        end
      end
    end
  end

  // Called at posedge+1; counts edges until done is seen. poke >= 0 raises a stray start
  // with unrelated operands for one cycle at that count.
  task automatic wait_done(input int poke, output int n);
    n = 0;
    while (!bus.done && n < 40) begin
      if (poke >= 0 && n == poke) begin
        check("busy_at_poke", 32'(bus.busy), 32'd1);
        bus.start    = 1'b1;
        bus.dividend = 16'h0101;
        bus.divisor  = 8'd3;
      end else if (poke >= 0 && n == poke + 1) begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [2*Size-1:0] dvd, input logic [Size-1:0] dvs,
                        input int poke);
    int n;
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    sb.push_back(model(dvd, dvs));
    #1;
    bus.start    = 1'b0;
    bus.dividend = 16'($urandom);
    bus.divisor  = 8'($urandom);
    wait_done(poke, n);
    check($sformatf("latency d=%0h b=%0h", dvd, dvs), 32'(n), (dvs == '0) ? 32'd0 : 32'd16);
  endtask

  initial begin
    int n;
    logic [2*Size-1:0] rd;
    logic [Size-1:0]   rb;
    errors = 0;
    checks = 0;
    op_idx = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.quotient", 32'(bus.quotient), 32'd0);
    check("rst.remainder", 32'(bus.remainder), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.flags", {30'd0, bus.div_zero, bus.ovf}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(16'd2607, 8'd200, -1);
    run_op(16'h1234, 8'd0, -1);
    run_op(16'hFFFF, 8'd1, -1);
    run_op(16'd2607, 8'd200, 5);

    // Reset partway through CALC: no result, everything cleared.
    bus.start    = 1'b1;
    bus.dividend = 16'd40000;
    bus.divisor  = 8'd77;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("pre_reset.busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset.quotient", 32'(bus.quotient), 32'd0);
    check("mid_reset.remainder", 32'(bus.remainder), 32'd0);
    check("mid_reset.busy", 32'(bus.busy), 32'd0);
    check("mid_reset.done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset.busy", 32'(bus.busy), 32'd0);
    run_op(16'd100, 8'd7, -1);

    // Start held high through DONE: second op accepted in the DONE cycle.
    bus.start    = 1'b1;
    bus.dividend = 16'd1000;
    bus.divisor  = 8'd9;
    @(posedge clk);
    sb.push_back(model(16'd1000, 8'd9));
    #1;
    bus.dividend = 16'd50;
    bus.divisor  = 8'd5;
    wait_done(-1, n);
    check("b2b.first_latency", 32'(n), 32'd16);
    @(posedge clk);
    sb.push_back(model(16'd50, 8'd5));
    #1;
    bus.start = 1'b0;
    wait_done(-1, n);
    check("b2b.second_latency", 32'(n), 32'd16);

    for (int i = 0; i < 1000; i++) begin
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      rd = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047));
      run_op(rd, rb, -1);
    end

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

endmodule
